// File: rtl/set_assoc_cache.sv
// set_assoc_cache: two-way set-associative, word-granular, write-through/no-write-allocate data cache
// Ports: clk/rst (sync, active-high); req_* CPU request (valid/ready/we/addr/wdata);
//        resp_valid_o/resp_rdata_o/hit_o one-cycle completion; mem_* memory request held until
//        mem_ack_i; hit_count_o/miss_count_o saturating statistics.
module set_assoc_cache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SET_WIDTH   = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [DATA_WIDTH-1:0]  req_wdata_i,
    output logic                   resp_valid_o,
    output logic [DATA_WIDTH-1:0]  resp_rdata_o,
    output logic                   hit_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0]  mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
    output logic [COUNT_WIDTH-1:0] hit_count_o,
    output logic [COUNT_WIDTH-1:0] miss_count_o
);
    localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - 2;
    localparam int SETS      = 1 << SET_WIDTH;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM} state_t;

    state_t                 r_state;
    logic [SETS-1:0]        r_valid0, r_valid1, r_lru;
    logic [TAG_WIDTH-1:0]   r_tag0 [SETS];
    logic [TAG_WIDTH-1:0]   r_tag1 [SETS];
    logic [DATA_WIDTH-1:0]  r_data0 [SETS];
    logic [DATA_WIDTH-1:0]  r_data1 [SETS];
    logic [TAG_WIDTH-1:0]   r_req_tag;
    logic [SET_WIDTH-1:0]   r_req_set;
    logic                   r_req_hit;
    logic [COUNT_WIDTH-1:0] r_hits, r_misses;

    logic [SET_WIDTH-1:0] w_set;
    logic [TAG_WIDTH-1:0] w_tag;
    logic                 w_hit0, w_hit1, w_hit, w_victim, w_unused;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_set        = req_addr_i[SET_WIDTH+1:2];
    assign w_tag        = req_addr_i[ADDR_WIDTH-1:SET_WIDTH+2];
    assign w_hit0       = r_valid0[w_set] && r_tag0[w_set] == w_tag;
    assign w_hit1       = r_valid1[w_set] && r_tag1[w_set] == w_tag;
    assign w_hit        = w_hit0 || w_hit1;
    // Fill prefers an empty way (way0 first); only a full set consults LRU.
    assign w_victim     = !r_valid0[r_req_set] ? 1'b0 : !r_valid1[r_req_set] ? 1'b1 : r_lru[r_req_set];
    assign w_unused     = ^req_addr_i[1:0];
    assign req_ready_o  = r_state == IDLE;
    assign hit_count_o  = r_hits;
    assign miss_count_o = r_misses;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_valid0     <= '0;
            r_valid1     <= '0;
            r_lru        <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            hit_o        <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            case (r_state)
                IDLE: if (req_valid_i) begin
                    r_req_tag <= w_tag;
                    r_req_set <= w_set;
                    r_req_hit <= w_hit;
                    if (w_hit) begin
                        r_lru[w_set] <= ~w_hit1;
                        r_hits       <= sat_inc(r_hits);
                    end else begin
                        r_misses <= sat_inc(r_misses);
                    end
                    // Writes always go to memory; only read hits complete locally.
                    if (req_we_i || !w_hit) begin
                        r_state     <= req_we_i ? WR_MEM : RD_MISS;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= req_we_i;
                        mem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_o <= req_wdata_i;
                    end else begin
                        resp_valid_o <= 1'b1;
                        hit_o        <= 1'b1;
                        resp_rdata_o <= w_hit1 ? r_data1[w_set] : r_data0[w_set];
                    end
                    if (req_we_i && w_hit0) r_data0[w_set] <= req_wdata_i;
                    if (req_we_i && w_hit1) r_data1[w_set] <= req_wdata_i;
                end
                RD_MISS: if (mem_ack_i) begin
                    if (w_victim) begin
                        r_valid1[r_req_set] <= 1'b1;
                        r_tag1[r_req_set]   <= r_req_tag;
                        r_data1[r_req_set]  <= mem_rdata_i;
                    end else begin
                        r_valid0[r_req_set] <= 1'b1;
                        r_tag0[r_req_set]   <= r_req_tag;
                        r_data0[r_req_set]  <= mem_rdata_i;
                    end
                    r_lru[r_req_set] <= ~w_victim;
                    resp_valid_o     <= 1'b1;
                    hit_o            <= 1'b0;
                    resp_rdata_o     <= mem_rdata_i;
                    mem_req_o        <= 1'b0;
                    r_state          <= IDLE;
                end
                WR_MEM: if (mem_ack_i) begin
                    resp_valid_o <= 1'b1;
                    hit_o        <= r_req_hit;
                    mem_req_o    <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
